fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of PC, address and instruction.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 redirect_valid  input  1  SHALL be a one-cycle branch/jump taken pulse from execute.
REQ-006 redirect_target  input  DATA_WIDTH  SHALL be the new fetch PC, valid with redirect_valid.
REQ-007 imem_req_valid  output  1  SHALL indicate a fetch request is offered.
REQ-008 imem_req_ready  input  1  SHALL indicate memory accepts the request this cycle.
REQ-009 imem_addr  output  DATA_WIDTH  SHALL be the request address, sampled by memory only at handshake.
REQ-010 imem_rsp_valid  input  1  SHALL mark imem_rsp_data valid; one response per accepted request, in order, latency >= 1.
REQ-011 imem_rsp_data  input  DATA_WIDTH  SHALL be the fetched instruction.
REQ-012 inst_valid  output  1  SHALL indicate that the buffer head holds an instruction.
REQ-013 inst_ready  input  1  SHALL be decode accepting the head; a pop occurs when inst_valid and inst_ready are both 1.
REQ-014 inst_data, inst_pc  output  DATA_WIDTH each  SHALL be the head instruction and its PC.
REQ-015 misalign_err  output  1  SHALL pulse for one cycle when redirect_target[1:0] != 0.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and DISCARD.
REQ-017 The FSM SHALL move from IDLE to REQ on the cycle after reset deasserts.
REQ-018 In REQ, imem_req_valid SHALL be 1 only when buf_count < 2, with imem_addr = fetch_pc.
REQ-019 On a handshake in REQ (valid and ready both 1), the FSM SHALL go to WAIT; at most one request SHALL be outstanding.
REQ-020 In WAIT, on imem_rsp_valid, the block SHALL push {imem_rsp_data, fetch_pc} into the 2-entry FIFO, set fetch_pc to fetch_pc + 4 (mod 2^DATA_WIDTH, wrap from 32'hFFFF_FFFC to 0), and return to REQ.
REQ-021 Back-to-back operation SHALL be supported: a request SHALL be issued the cycle after a response if buf_count < 2.
REQ-022 The FIFO SHALL support a simultaneous push and pop at count 1 or 2, leaving the count unchanged.
REQ-023 Pop SHALL be ignored when the FIFO is empty.
REQ-024 Push with count 2 SHALL be unreachable; an assertion SHALL flag it.
REQ-025 On redirect_valid, the FIFO SHALL be flushed (count 0, inst_valid 0 next cycle), overriding any same-cycle pop or push.
REQ-026 On redirect_valid, fetch_pc SHALL be set to {redirect_target[DATA_WIDTH-1:2], 2'b00}.
REQ-027 Redirect in IDLE or REQ without handshake: next state SHALL be REQ; the request address SHALL change to the new target (permitted only on redirect).
REQ-028 Redirect in REQ with a same-cycle handshake: next state SHALL be DISCARD.
REQ-029 Redirect in WAIT without imem_rsp_valid: next state SHALL be DISCARD.
REQ-030 Redirect in WAIT with imem_rsp_valid: the response SHALL be dropped and the next state SHALL be REQ.
REQ-031 In DISCARD, imem_req_valid SHALL be 0; on imem_rsp_valid the data SHALL be dropped, fetch_pc SHALL NOT increment, and the next state SHALL be REQ.
REQ-032 A further redirect while in DISCARD SHALL update fetch_pc, and the FSM SHALL stay in DISCARD.
REQ-033 inst_data and inst_pc SHALL be stable while inst_valid is 1 and inst_ready is 0.
REQ-034 Instruction latency SHALL be: a response at cycle N is visible on inst_valid at cycle N+1.

Reset
REQ-035 While rst = 0 at a clock edge: state = IDLE, fetch_pc = RESET_PC, buf_count = 0, FIFO pointers = 0, discard flag = 0.
REQ-036 While rst = 0 at a clock edge: imem_req_valid, inst_valid and misalign_err = 0; inst_data, inst_pc and imem_addr = 0.
REQ-037 Reset asserted mid-WAIT SHALL abandon the outstanding request; the memory side is reset concurrently.

Verification
REQ-038 Reset release, ready=1, 1-cycle memory, inst_ready=1 -> requests at 0x0, 0x4, 0x8; inst_pc 0x0, 0x4, 0x8 with matching data.
REQ-039 inst_ready=0 for 6 cycles -> FIFO fills at 2 entries (0x0, 0x4), imem_req_valid = 0, no address skipped after inst_ready returns to 1.
REQ-040 Redirect to 0x100 while in WAIT for 0x8; response arrives 2 cycles later -> response discarded, next request 0x100, first inst_pc 0x100, FIFO flushed.
REQ-041 Redirect to 0x200 in the same cycle as imem_rsp_valid and a pop -> no push, count 0, next imem_addr 0x200.
REQ-042 Redirect target 0x203 -> misalign_err pulses once, next imem_addr 0x200.
REQ-043 RESET_PC = 0xFFFF_FFFC -> inst_pc sequence 0xFFFF_FFFC, 0x0000_0000; rst low mid-WAIT -> IDLE, imem_addr = RESET_PC after release.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle.
// Groups the redirect input, the instruction-memory request/response
// channel and the decode-facing instruction channel.
//   master : the fetch controller (drives imem request and instruction outputs)
//   slave  : the environment (execute redirect, memory, decode)
interface fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  misalign_err;

  modport master (
    input  redirect_valid, redirect_target,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_ready,
    output imem_req_valid, imem_addr,
    output inst_valid, inst_data, inst_pc,
    output misalign_err
  );

  modport slave (
    output redirect_valid, redirect_target,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_ready,
    input  imem_req_valid, imem_addr,
    input  inst_valid, inst_data, inst_pc,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one outstanding instruction-memory request at a time, buffers
// returned instructions with their PC in a 2-entry FIFO for decode, and
// handles branch/jump redirects (flush, refetch, drop of in-flight data).
// Ports:
//   clk : clock, all state updates on rising edge
//   rst : synchronous active-low reset
//   bus : fetch_ctrl_if master (redirect, imem req/rsp, inst out, misalign_err)
module fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [DATA_WIDTH-1:0] fifo_pc   [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  always_comb begin
    bus.imem_req_valid = (state == ST_REQ) && (buf_count < 2'd2);
    bus.imem_addr      = (state == ST_IDLE) ? '0 : fetch_pc;
    bus.inst_valid     = (buf_count != 2'd0);
    // Head is forced to zero when empty so outputs are clean in reset.
    bus.inst_data      = bus.inst_valid ? fifo_data[rd_ptr] : '0;
    bus.inst_pc        = bus.inst_valid ? fifo_pc[rd_ptr]   : '0;
  end

  // A redirect overrides any same-cycle push or pop: the FIFO is flushed.
  always_comb begin
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    push     = (state == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.redirect_valid)
          state_nxt = req_fire ? ST_DISCARD : ST_REQ;
        else if (req_fire)
          state_nxt = ST_WAIT;
      end
      // With a response this cycle nothing is left in flight, so a
      // coincident redirect needs no DISCARD pass.
      ST_WAIT: begin
        if (bus.imem_rsp_valid)
          state_nxt = ST_REQ;
        else if (bus.redirect_valid)
          state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (bus.imem_rsp_valid)
          state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      fetch_pc     <= RESET_PC;
      buf_count    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.misalign_err <= bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        fetch_pc  <= {bus.redirect_target[DATA_WIDTH-1:2], 2'b00};
        buf_count <= '0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + DATA_WIDTH'(4);
          wr_ptr   <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   buf_count <= buf_count + 2'd1;
          2'b01:   buf_count <= buf_count - 2'd1;
          default: buf_count <= buf_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rsp_data;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

  // Requests are only issued below two entries with one outstanding,
  // so a push into a full buffer indicates a broken invariant.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (buf_count == 2'd2)));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic rst_w = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();
  fetch_ctrl_if #(.DATA_WIDTH(32)) bus_w ();

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .bus(bus_w));

  int nchk = 0;
  int err  = 0;

  // Reference model: decode sees the sequential PC stream of the current
  // redirect epoch; responses to requests from an older epoch are dropped.
  ent_t        q[$];
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_tag, mem_due, epoch, cyc, lat;
  logic [31:0] exp_pc;
  logic        exp_req_valid, exp_mis, idle;
  logic        drv_redirect, drv_ready, drv_inst_ready;
  logic [31:0] drv_target;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          mis_cnt;

  logic        w_busy;
  logic [31:0] w_addr;
  logic [31:0] w_pcs[$];
  logic [31:0] w_dats[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    q.delete();
    mem_busy      = 1'b0;
    exp_pc        = 32'h0;
    exp_req_valid = 1'b0;
    exp_mis       = 1'b0;
    idle          = 1'b1;
  endtask

  // One clock cycle of the main DUT, entered and left at a falling edge.
  task automatic step();
    logic        hs, redir, rsp;
    logic [31:0] tgt;
    ent_t        e;
    nchk++;
    if (bus.inst_valid !== (q.size() != 0)) begin
      err++; $display("FAIL inst_valid got=%b exp=%b cyc=%0d", bus.inst_valid, q.size() != 0, cyc);
    end
    if (q.size() != 0) begin
      nchk++;
      if (bus.inst_pc !== q[0].pc) begin
        err++; $display("FAIL inst_pc got=%h exp=%h cyc=%0d", bus.inst_pc, q[0].pc, cyc);
      end
      nchk++;
      if (bus.inst_data !== q[0].data) begin
        err++; $display("FAIL inst_data got=%h exp=%h cyc=%0d", bus.inst_data, q[0].data, cyc);
      end
    end
    nchk++;
    if (bus.imem_req_valid !== exp_req_valid) begin
      err++; $display("FAIL req_valid got=%b exp=%b cyc=%0d", bus.imem_req_valid, exp_req_valid, cyc);
    end
    if (exp_req_valid) begin
      nchk++;
      if (bus.imem_addr !== exp_pc) begin
        err++; $display("FAIL imem_addr got=%h exp=%h cyc=%0d", bus.imem_addr, exp_pc, cyc);
      end
    end
    nchk++;
    if (bus.misalign_err !== exp_mis) begin
      err++; $display("FAIL misalign_err got=%b exp=%b cyc=%0d", bus.misalign_err, exp_mis, cyc);
    end
    if (idle) begin
      nchk++;
      if (bus.imem_addr !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0) begin
        err++; $display("FAIL idle_zero got addr=%h pc=%h data=%h exp=0 cyc=%0d",
                        bus.imem_addr, bus.inst_pc, bus.inst_data, cyc);
      end
    end
    if (bus.misalign_err === 1'b1) mis_cnt++;

    redir = rst && drv_redirect;
    tgt   = drv_target;
    bus.redirect_valid  = redir;
    bus.redirect_target = tgt;
    bus.imem_req_ready  = drv_ready;
    bus.inst_ready      = drv_inst_ready;
    rsp = rst && mem_busy && (cyc >= mem_due);
    bus.imem_rsp_valid  = rsp;
    bus.imem_rsp_data   = rsp ? f(mem_addr) : $urandom();

    if (!rst) begin
      model_reset();
    end else begin
      hs = (bus.imem_req_valid === 1'b1) && drv_ready;
      if (bus.inst_valid === 1'b1 && drv_inst_ready && !redir) pop_log.push_back(bus.inst_pc);
      if (q.size() != 0 && drv_inst_ready && !redir) void'(q.pop_front());
      if (rsp) begin
        mem_busy = 1'b0;
        if (mem_tag == epoch && !redir) begin
          e.pc = mem_addr; e.data = f(mem_addr);
          q.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (hs) begin
        mem_busy = 1'b1; mem_addr = bus.imem_addr; mem_tag = epoch; mem_due = cyc + lat;
        if (!redir) req_log.push_back(bus.imem_addr);
      end
      if (redir) begin
        q.delete();
        exp_pc = {tgt[31:2], 2'b00};
        epoch++;
      end
      exp_mis       = redir && (tgt[1:0] != 2'b00);
      idle          = 1'b0;
      exp_req_valid = !mem_busy && (q.size() < 2);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv_redirect = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; drv_redirect = 1'b0; drv_ready = 1'b1; drv_inst_ready = 1'b1; lat = 1;
    repeat (3) step();
    nchk++; if (bus.imem_req_valid !== 1'b0) begin err++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
    nchk++; if (bus.inst_valid !== 1'b0) begin err++; $display("FAIL rst_inst_valid got=%b exp=0", bus.inst_valid); end
    nchk++; if (bus.misalign_err !== 1'b0) begin err++; $display("FAIL rst_misalign got=%b exp=0", bus.misalign_err); end
    nchk++; if (bus.imem_addr !== 32'h0) begin err++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
    nchk++; if (bus.inst_pc !== 32'h0) begin err++; $display("FAIL rst_inst_pc got=%h exp=0", bus.inst_pc); end
    nchk++; if (bus.inst_data !== 32'h0) begin err++; $display("FAIL rst_inst_data got=%h exp=0", bus.inst_data); end
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    req_log.delete(); pop_log.delete();
    rst = 1'b1; drv_ready = 1'b1; drv_inst_ready = 1'b1; lat = 1;
    repeat (12) step();
    for (int i = 0; i < 3; i++) begin
      want = 32'(i * 4);
      nchk++;
      if (req_log.size() <= i || req_log[i] !== want) begin
        err++; $display("FAIL seq_req%0d got=%h exp=%h", i, (req_log.size() > i) ? req_log[i] : 32'hx, want);
      end
      nchk++;
      if (pop_log.size() <= i || pop_log[i] !== want) begin
        err++; $display("FAIL seq_pop%0d got=%h exp=%h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, want);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    pop_log.delete();
    drv_ready = 1'b1; drv_inst_ready = 1'b0; lat = 1;
    repeat (6) step();
    nchk++; if (bus.imem_req_valid !== 1'b0) begin err++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
    nchk++; if (bus.inst_valid !== 1'b1) begin err++; $display("FAIL bp_inst_valid got=%b exp=1", bus.inst_valid); end
    nchk++; if (bus.inst_pc !== 32'h0) begin err++; $display("FAIL bp_head_pc got=%h exp=0", bus.inst_pc); end
    drv_inst_ready = 1'b1;
    repeat (12) step();
    nchk++;
    if (pop_log.size() < 4) begin err++; $display("FAIL bp_pops got=%0d exp>=4", pop_log.size()); end
    for (int i = 0; i < pop_log.size(); i++) begin
      nchk++;
      if (pop_log[i] !== 32'(i * 4)) begin
        err++; $display("FAIL bp_seq%0d got=%h exp=%h", i, pop_log[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    int   nreq, npop;
    do_reset();
    req_log.delete(); pop_log.delete();
    drv_ready = 1'b1; drv_inst_ready = 1'b1; lat = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req_valid === 1'b1 && bus.imem_addr === 32'h8) begin
        lat = 3; found = 1'b1;
      end
      step();
    end
    nchk++; if (!found) begin err++; $display("FAIL rw_reach_8 got=0 exp=1"); end
    nreq = req_log.size(); npop = pop_log.size();
    drv_redirect = 1'b1; drv_target = 32'h100;
    step();
    drv_redirect = 1'b0; lat = 1;
    nchk++; if (bus.inst_valid !== 1'b0) begin err++; $display("FAIL rw_flush got=%b exp=0", bus.inst_valid); end
    nchk++; if (bus.imem_req_valid !== 1'b0) begin err++; $display("FAIL rw_discard_req got=%b exp=0", bus.imem_req_valid); end
    repeat (10) step();
    nchk++;
    if (req_log.size() <= nreq || req_log[nreq] !== 32'h100) begin
      err++; $display("FAIL rw_next_req got=%h exp=00000100", (req_log.size() > nreq) ? req_log[nreq] : 32'hx);
    end
    nchk++;
    if (pop_log.size() <= npop || pop_log[npop] !== 32'h100) begin
      err++; $display("FAIL rw_first_pc got=%h exp=00000100", (pop_log.size() > npop) ? pop_log[npop] : 32'hx);
    end
  endtask

  task automatic test_redirect_rsp_pop();
    logic found;
    do_reset();
    drv_ready = 1'b1; drv_inst_ready = 1'b0; lat = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && cyc >= mem_due && q.size() == 1 && bus.inst_valid === 1'b1) begin
        drv_redirect = 1'b1; drv_target = 32'h200; drv_inst_ready = 1'b1; found = 1'b1;
      end
      step();
    end
    drv_redirect = 1'b0;
    nchk++; if (!found) begin err++; $display("FAIL rp_reach got=0 exp=1"); end
    nchk++; if (bus.inst_valid !== 1'b0) begin err++; $display("FAIL rp_count0 got=%b exp=0", bus.inst_valid); end
    nchk++; if (bus.imem_req_valid !== 1'b1) begin err++; $display("FAIL rp_req_valid got=%b exp=1", bus.imem_req_valid); end
    nchk++; if (bus.imem_addr !== 32'h200) begin err++; $display("FAIL rp_addr got=%h exp=00000200", bus.imem_addr); end
    repeat (4) step();
  endtask

  task automatic test_misalign();
    int m0, nreq;
    drv_ready = 1'b1; drv_inst_ready = 1'b1; lat = 1;
    repeat (2) step();
    m0 = mis_cnt; nreq = req_log.size();
    drv_redirect = 1'b1; drv_target = 32'h203;
    step();
    drv_redirect = 1'b0;
    nchk++; if (bus.misalign_err !== 1'b1) begin err++; $display("FAIL mis_pulse got=%b exp=1", bus.misalign_err); end
    repeat (8) step();
    nchk++; if (mis_cnt - m0 != 1) begin err++; $display("FAIL mis_once got=%0d exp=1", mis_cnt - m0); end
    nchk++;
    if (req_log.size() <= nreq || req_log[nreq] !== 32'h200) begin
      err++; $display("FAIL mis_addr got=%h exp=00000200", (req_log.size() > nreq) ? req_log[nreq] : 32'hx);
    end
  endtask

  task automatic test_random();
    int npop;
    do_reset();
    npop = pop_log.size();
    for (int i = 0; i < 3000; i++) begin
      drv_ready      = ($urandom_range(0, 3) != 0);
      drv_inst_ready = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 4);
      drv_redirect   = ($urandom_range(0, 19) == 0);
      drv_target     = $urandom();
      rst            = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1; drv_redirect = 1'b0;
    nchk++; if (pop_log.size() - npop < 100) begin err++; $display("FAIL rnd_progress got=%0d exp>=100", pop_log.size() - npop); end
  endtask

  task automatic wrap_cycle();
    if (bus_w.inst_valid === 1'b1) begin
      w_pcs.push_back(bus_w.inst_pc); w_dats.push_back(bus_w.inst_data);
    end
    bus_w.imem_rsp_valid = w_busy;
    bus_w.imem_rsp_data  = w_busy ? f(w_addr) : 32'h0;
    if (w_busy) w_busy = 1'b0;
    else if (bus_w.imem_req_valid === 1'b1) begin
      w_busy = 1'b1; w_addr = bus_w.imem_addr;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] wp[2];
    bus_w.redirect_valid = 1'b0; bus_w.redirect_target = 32'h0;
    bus_w.imem_req_ready = 1'b1; bus_w.inst_ready = 1'b1;
    bus_w.imem_rsp_valid = 1'b0; bus_w.imem_rsp_data = 32'h0;
    w_busy = 1'b0; rst_w = 1'b0;
    repeat (2) @(negedge clk);
    rst_w = 1'b1;
    repeat (10) wrap_cycle();
    wp[0] = 32'hFFFF_FFFC; wp[1] = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (w_pcs.size() <= i || w_pcs[i] !== wp[i] || w_dats[i] !== f(wp[i])) begin
        err++; $display("FAIL wrap_pc%0d got=%h/%h exp=%h/%h", i,
                        (w_pcs.size() > i) ? w_pcs[i] : 32'hx, (w_dats.size() > i) ? w_dats[i] : 32'hx, wp[i], f(wp[i]));
      end
    end
    for (int i = 0; i < 6 && !w_busy; i++) wrap_cycle();
    nchk++; if (!w_busy || bus_w.imem_req_valid !== 1'b0) begin err++; $display("FAIL wrap_in_wait got=%b exp=1", w_busy); end
    rst_w = 1'b0; w_busy = 1'b0; bus_w.imem_rsp_valid = 1'b0;
    @(negedge clk);
    nchk++; if (bus_w.imem_req_valid !== 1'b0 || bus_w.inst_valid !== 1'b0 || bus_w.imem_addr !== 32'h0) begin
      err++; $display("FAIL wrap_rst got=%b/%b/%h exp=0/0/0", bus_w.imem_req_valid, bus_w.inst_valid, bus_w.imem_addr);
    end
    rst_w = 1'b1;
    @(negedge clk);
    nchk++; if (bus_w.imem_req_valid !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC) begin
      err++; $display("FAIL wrap_release got=%b/%h exp=1/fffffffc", bus_w.imem_req_valid, bus_w.imem_addr);
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0; bus.inst_ready = 1'b0;
    bus_w.redirect_valid = 1'b0; bus_w.redirect_target = 32'h0;
    bus_w.imem_req_ready = 1'b0; bus_w.imem_rsp_valid = 1'b0;
    bus_w.imem_rsp_data  = 32'h0; bus_w.inst_ready = 1'b0;
    drv_redirect = 1'b0; drv_target = 32'h0; drv_ready = 1'b0; drv_inst_ready = 1'b0;
    epoch = 0; cyc = 0; lat = 1; mis_cnt = 0; mem_addr = 32'h0; mem_tag = 0; mem_due = 0;
    w_busy = 1'b0; w_addr = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp_pop();
    test_misalign();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", err, nchk);
    $finish;
  end

endmodule
